result_unloader: RTL and testbench
==================================

# result_unloader

Reads completed result rows out of the results SRAM and streams them to the host one partial sum per beat over a valid/ready handshake. It is the read-side counterpart of the systolic array's result write path. The array, through the deskew and reverse logic, writes one MATRIX_SIZE×PARTIAL_SUM_BW row per address. This block walks a programmed address range, fetches each row with the SRAM's one-cycle synchronous read, and serializes the row column by column. It sits between the results SRAM read port and the host interface, and owns that read port while busy.

## Interface
Parameters:
- ADDRESSSIZE, 10, results SRAM address width
- PARTIAL_SUM_BW, 20, width of one partial sum (one output beat)
- MATRIX_SIZE, 8, partial sums per SRAM row; must be a power of two ≥ 2

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  begin a transfer; sampled only in IDLE
- base_addr  in  ADDRESSSIZE  first row address, captured on accepted start
- num_rows  in  ADDRESSSIZE+1  rows to transfer (0 to 2^ADDRESSSIZE), captured on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the transfer completes
- res_addr  out  ADDRESSSIZE  registered results SRAM address
- res_we  out  1  results SRAM write enable; constant 0
- res_rdata  in  MATRIX_SIZE*PARTIAL_SUM_BW  SRAM read data, valid the cycle after the address is sampled
- out_valid  out  1  out_data holds a valid beat
- out_ready  in  1  host accepts the beat when out_valid && out_ready
- out_data  out  PARTIAL_SUM_BW  current partial sum
- out_last  out  1  high with the final beat of the final row

## Operation
- States: IDLE, ADDR, LOAD, SEND, DONE.
- IDLE, start=1, num_rows≠0: capture base_addr into res_addr and num_rows into the row counter, then go to ADDR.
- IDLE, start=1, num_rows=0: go directly to DONE. No SRAM access and no beats.
- ADDR: res_addr is stable. The SRAM samples it at the end of the cycle. Next state is LOAD.
- LOAD: res_rdata is valid. Load it into the row shift register, clear the column counter, and go to SEND.
- SEND: out_valid=1 and out_data = shift register bits [PARTIAL_SUM_BW-1:0]. Column 0 is the lowest slice and is sent first.
- On each handshake in SEND, shift the register right by PARTIAL_SUM_BW and increment the column counter.
- Handshake on column MATRIX_SIZE-1:
  - If rows remain after this one: decrement the row counter, set res_addr to res_addr+1, and go to ADDR.
  - Otherwise: go to DONE.
- res_addr increments modulo 2^ADDRESSSIZE, so the range wraps past the top address to 0.
- out_last = SEND && final row && column = MATRIX_SIZE-1.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE; a start asserted while busy is not queued.
- Data is passed through unmodified: no sign extension, truncation or reordering.

## Timing
- Reset values: state IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=0, res_addr=0, res_we=0, all counters 0.
- Asserting rstn mid-transfer aborts immediately. There is no done pulse, and the in-flight row is discarded.
- All outputs are registered or decoded from the state register only. There is no combinational path from out_ready to any output.
- Start latency: if start is accepted at edge E0, res_addr=base_addr from E0, res_rdata is captured at E2, and out_valid rises after E2.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and out_valid hold stable. The counters, shift register and res_addr also hold.
- Throughput with out_ready held high: MATRIX_SIZE beats per MATRIX_SIZE+2 cycles. There is a two-cycle out_valid gap (ADDR, LOAD) between rows.
- Completion: done pulses in the cycle after the last handshake, and busy falls in the following cycle.
- With num_rows=0, done pulses in the cycle after start is accepted.

## Test plan
- Single row: preload addr 5 with columns 0..7 = 1..8, set base_addr=5, num_rows=1, pulse start, hold out_ready=1. Required: beats 1,2,…,8 on 8 consecutive cycles starting 2 cycles after the start edge, out_last only on beat 8, then one done pulse, then busy=0.
- Multi-row with wrap: base_addr=1022, num_rows=3, each row filled with a distinct pattern. Required: res_addr sequence 1022, 1023, 0; 24 beats in order; a 2-cycle out_valid gap between rows.
- Backpressure: toggle out_ready randomly at 50%. Required: out_data/out_last stable while stalled, no beats lost or duplicated, final stream identical to the no-stall run.
- Zero rows and ignored start: num_rows=0 gives a done pulse one cycle after start, no out_valid and res_addr unchanged. Separately, a start pulsed mid-transfer with a different base_addr must not alter the stream.
- Reset mid-transfer: drop rstn during column 3 of row 1 of 4. Required: immediate out_valid=0, busy=0, res_addr=0 and no done pulse. A fresh start afterward completes correctly.
- Full-width data: all columns = 20'hFFFFF and 20'h80000. Required: values pass out bit-exact with no sign handling, and res_we stays 0 throughout.

Source files
------------

// File: rtl/result_unloader_if.sv
// Host-side result stream: one partial sum per beat over valid/ready.
interface result_unloader_if #(
    parameter int unsigned PARTIAL_SUM_BW = 20
);
    logic                      out_valid;
    logic                      out_ready;
    logic [PARTIAL_SUM_BW-1:0] out_data;
    logic                      out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/result_unloader.sv
// Walks a row range of the results SRAM and serializes each row,
// column 0 first, onto the host result stream.
module result_unloader #(
    parameter int unsigned ADDRESSSIZE    = 10,
    parameter int unsigned PARTIAL_SUM_BW = 20,
    parameter int unsigned MATRIX_SIZE    = 8
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic [ADDRESSSIZE:0]                  num_rows,
    output logic                                  busy,
    output logic                                  done,
    output logic [ADDRESSSIZE-1:0]                res_addr,
    output logic                                  res_we,
    input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] res_rdata,
    result_unloader_if.master                     out_if
);
    localparam int unsigned ROW_W = MATRIX_SIZE * PARTIAL_SUM_BW;
    localparam int unsigned CNT_W = ADDRESSSIZE + 1;
    localparam int unsigned COL_W = $clog2(MATRIX_SIZE);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MATRIX_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESSSIZE-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]         rows_q, rows_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         shift_q, shift_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;

    // rows_q counts rows still owed, including the one in flight.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rows_d  = rows_q;
        col_d   = col_q;
        shift_d = shift_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        addr_d  = base_addr;
                        rows_d  = num_rows;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ADDR: state_d = S_LOAD;
            S_LOAD: begin
                shift_d = res_rdata;
                col_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_if.out_ready) begin
                    shift_d = shift_q >> PARTIAL_SUM_BW;
                    col_d   = col_q + COL_W'(1);
                    if (col_q == LAST_COL) begin
                        if (rows_q != CNT_W'(1)) begin
                            rows_d  = rows_q - CNT_W'(1);
                            addr_d  = addr_q + ADDRESSSIZE'(1);
                            state_d = S_ADDR;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Status outputs are precomputed from the next state so they come straight from flops.
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        valid_d = (state_d == S_SEND);
        last_d  = (state_d == S_SEND) && (rows_d == CNT_W'(1)) && (col_d == LAST_COL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rows_q  <= '0;
            col_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rows_q  <= rows_d;
            col_q   <= col_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign res_addr         = addr_q;
    assign res_we           = 1'b0;
    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = shift_q[PARTIAL_SUM_BW-1:0];
    assign out_if.out_last  = last_q;
endmodule

// File: tb/tb_result_unloader.sv
// Directed + randomized bench for result_unloader against a row/column stream model.
module tb_result_unloader;
    localparam int AW   = 10;
    localparam int PSBW = 20;
    localparam int MS   = 8;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [AW:0]       num_rows;
    logic              busy;
    logic              done;
    logic [AW-1:0]     res_addr;
    logic              res_we;
    logic [MS*PSBW-1:0] res_rdata;

    result_unloader_if #(.PARTIAL_SUM_BW(PSBW)) oif ();

    result_unloader #(
        .ADDRESSSIZE(AW),
        .PARTIAL_SUM_BW(PSBW),
        .MATRIX_SIZE(MS)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .base_addr(base_addr),
        .num_rows(num_rows),
        .busy(busy),
        .done(done),
        .res_addr(res_addr),
        .res_we(res_we),
        .res_rdata(res_rdata),
        .out_if(oif)
    );

    always #5 clk = ~clk;

    // Results SRAM model with one-cycle synchronous read.
    logic [MS*PSBW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) res_rdata <= mem[res_addr];

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MS*PSBW-1:0] rand_row();
        logic [MS*PSBW-1:0] r;
        for (int i = 0; i < MS; i++) r[i*PSBW +: PSBW] = PSBW'($urandom());
        return r;
    endfunction

    task automatic set_col(input int addr, input int col, input logic [PSBW-1:0] v);
        logic [MS*PSBW-1:0] r;
        r = mem[addr];
        r[col*PSBW +: PSBW] = v;
        mem[addr] = r;
    endtask

    // Reference: beat idx of a transfer is column idx%MS of row (base + idx/MS) mod DEPTH.
    function automatic logic [PSBW-1:0] model_beat(input int base, input int idx);
        logic [MS*PSBW-1:0] r;
        r = mem[(base + idx / MS) % DEPTH];
        return r[(idx % MS)*PSBW +: PSBW];
    endfunction

    task automatic run_xfer(input string nm, input int base, input int n, input int rdy_pct,
                            input bit mid_start);
        logic [AW-1:0]   addr0;
        logic [PSBW-1:0] prev_data;
        logic            prev_last;
        bit              prev_stall;
        bit              rdy;
        bit              fin;
        int              nbeats, cyc, done_cnt, done_cyc, valid_cnt, we_bad, total;
        total = n * MS;
        nbeats = 0; done_cnt = 0; done_cyc = -1; valid_cnt = 0; we_bad = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; fin = 1'b0;
        @(negedge clk);
        addr0          = res_addr;
        start          = 1'b1;
        base_addr      = AW'(base);
        num_rows       = (AW+1)'(n);
        oif.out_ready  = 1'b0;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom());
        num_rows  = (AW+1)'($urandom_range(1, 7));
        cyc = -1;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                chk({nm, "_stall_valid"}, 64'(oif.out_valid), 64'(1));
                chk({nm, "_stall_data"}, 64'(oif.out_data), 64'(prev_data));
                chk({nm, "_stall_last"}, 64'(oif.out_last), 64'(prev_last));
            end
            if (res_we !== 1'b0) we_bad++;
            if (oif.out_valid) valid_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk({nm, "_busy_after_done"}, 64'(busy), 64'(0));
                chk({nm, "_done_width"}, 64'(done), 64'(0));
                fin = 1'b1;
            end
            if (mid_start && cyc == 4) begin
                start     = 1'b1;
                base_addr = AW'(base + 100);
                num_rows  = (AW+1)'(1);
            end else begin
                start = 1'b0;
            end
            rdy = ($urandom_range(99) < rdy_pct);
            oif.out_ready = rdy;
            if (oif.out_valid === 1'b1 && rdy) begin
                chk({nm, "_data"}, 64'(oif.out_data), 64'(model_beat(base, nbeats)));
                chk({nm, "_last"}, 64'(oif.out_last), 64'(nbeats == total - 1));
                chk({nm, "_addr"}, 64'(res_addr), 64'((base + nbeats / MS) % DEPTH));
                if (rdy_pct >= 100)
                    chk({nm, "_beat_cycle"}, 64'(cyc), 64'(2 + (nbeats / MS) * (MS + 2) + nbeats % MS));
                nbeats++;
            end
            prev_stall = (oif.out_valid === 1'b1) && !rdy;
            prev_data  = oif.out_data;
            prev_last  = oif.out_last;
        end
        start = 1'b0;
        oif.out_ready = 1'b0;
        chk({nm, "_finished"}, 64'(fin), 64'(1));
        chk({nm, "_nbeats"}, 64'(nbeats), 64'(total));
        chk({nm, "_done_count"}, 64'(done_cnt), 64'(1));
        chk({nm, "_we"}, 64'(we_bad), 64'(0));
        if (rdy_pct >= 100) chk({nm, "_done_cycle"}, 64'(done_cyc), 64'(n * (MS + 2)));
        if (n == 0) begin
            chk({nm, "_no_valid"}, 64'(valid_cnt), 64'(0));
            chk({nm, "_addr_kept"}, 64'(res_addr), 64'(addr0));
        end
    endtask

    initial begin
        int hs;
        bit reached;
        for (int a = 0; a < DEPTH; a++) mem[a] = rand_row();
        rstn = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; oif.out_ready = 1'b0;
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_valid", 64'(oif.out_valid), 64'(0));
        chk("rst_last", 64'(oif.out_last), 64'(0));
        chk("rst_data", 64'(oif.out_data), 64'(0));
        chk("rst_addr", 64'(res_addr), 64'(0));
        chk("rst_we", 64'(res_we), 64'(0));
        @(negedge clk);
        rstn = 1'b1;

        for (int c = 0; c < MS; c++) set_col(5, c, PSBW'(c + 1));
        run_xfer("single", 5, 1, 100, 1'b0);

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < MS; c++)
                set_col((1022 + r) % DEPTH, c, PSBW'(((r + 1) << 12) | (c * 17 + 3)));
        run_xfer("wrap", 1022, 3, 100, 1'b0);
        run_xfer("bp_wrap", 1022, 3, 50, 1'b0);

        for (int k = 0; k < 4; k++)
            run_xfer("rand", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 5)),
                     int'($urandom_range(30, 100)), 1'b0);

        run_xfer("zero", 77, 0, 100, 1'b0);
        run_xfer("mid_start", 40, 2, 100, 1'b1);

        // Abort during column 3 of row 1 of a four-row transfer.
        @(negedge clk);
        start = 1'b1; base_addr = AW'(200); num_rows = (AW+1)'(4);
        @(posedge clk);
        #1;
        start = 1'b0;
        oif.out_ready = 1'b1;
        hs = 0;
        reached = 1'b0;
        for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
            @(negedge clk);
            if (oif.out_valid === 1'b1) begin
                if (hs == MS + 3) reached = 1'b1;
                else hs++;
            end
        end
        chk("abort_reach", 64'(reached), 64'(1));
        chk("abort_beat", 64'(oif.out_data), 64'(model_beat(200, MS + 3)));
        rstn = 1'b0;
        #1;
        chk("abort_valid", 64'(oif.out_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_addr", 64'(res_addr), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_last", 64'(oif.out_last), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold_done", 64'(done), 64'(0));
            chk("abort_hold_busy", 64'(busy), 64'(0));
        end
        rstn = 1'b1;
        oif.out_ready = 1'b0;
        run_xfer("after_abort", 200, 4, 100, 1'b0);

        for (int c = 0; c < MS; c++) begin
            set_col(300, c, 20'hFFFFF);
            set_col(301, c, 20'h80000);
        end
        run_xfer("fullwidth", 300, 2, 70, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
